mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory-access/writeback stage of the cpu2 pipeline, directly upstream of the 16-entry register file.
- Accepts one instruction per cycle from execute and passes ALU results straight through to the register-file write port.
- Runs load/store ops on the 16-bit data bus with a stb/ack handshake, holding execute stalled until the bus transfer completes.
- Drives the register-file write inputs: write address, write data, write enable, high/low select, memtoreg and data ack.

Parameters:
TIMEOUT, 16, bus-ack wait limit in cycles before a transfer is aborted (min 2)
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
in_valid  in  1  instruction present from execute
in_load  in  1  instruction is a half-word load
in_store  in  1  instruction is a half-word store
in_we  in  1  instruction writes a register (ALU op or load)
in_highlow  in  1  1 = upper half-word [31:16], 0 = lower [15:0]
in_rd  in  5  destination register (0..15; bit 4 ignored)
in_alu  in  32  ALU result; for load/store, the byte address
in_sdata  in  32  store data; for high stores, [31:16] is driven
stall_o  out  1  execute must hold its outputs
data_addr_o  out  32  bus address
data_dat_o  out  16  bus write data
data_we_o  out  1  bus write strobe qualifier
data_stb_o  out  1  bus request
data_dat_i  in  16  bus read data
data_ack_i  in  1  bus acknowledge
wb_ra3  out  5  register-file write address
wb_wd3  out  32  register-file write data
wb_we3  out  1  register-file write enable
wb_highlow  out  1  register-file half select
wb_memtoreg  out  1  write data comes from memory
wb_data_ack  out  1  qualifies the memory half-word write
err_o  out  1  one-cycle pulse on bus timeout

Behaviour:
- Reset (synchronous): state=IDLE, counter=0, all outputs 0.
- FSM states:
  - IDLE: accepts an op when in_valid=1.
  - BUS: stb is held asserted.
  - WB: a one-cycle writeback of load data.
- IDLE, in_valid and neither in_load nor in_store (ALU op):
  - Next cycle: wb_we3=in_we, wb_ra3=in_rd, wb_wd3=in_alu, wb_memtoreg=0, wb_data_ack=0, wb_highlow=0.
  - Latency is 1; back-to-back ALU ops run at one per cycle.
- IDLE, in_valid and in_load or in_store:
  - Latch addr, rd, highlow, load/store and store half; go to BUS.
  - Store half = in_highlow ? in_sdata[31:16] : in_sdata[15:0].
  - Next cycle: data_stb_o=1, data_we_o=in_store, data_addr_o=latched addr, data_dat_o=latched half.
  - wb_we3=0 that cycle.
- In BUS, all bus outputs stay stable until ack.
- BUS with data_ack_i=1:
  - Drop stb/we the next cycle.
  - Load: capture data_dat_i, go to WB.
  - Store: go to IDLE; no register write.
- WB (one cycle):
  - wb_we3=1, wb_memtoreg=1, wb_data_ack=1, wb_highlow=latched highlow, wb_ra3=latched rd.
  - wb_wd3={16'b0, captured data}.
  - Then go to IDLE.
- stall_o=1 combinationally while state is BUS or WB, and also in IDLE when in_valid and (in_load|in_store).
  - Execute therefore holds the mem op and any following op until the stage returns to IDLE.
  - In IDLE the stage accepts the held op on the edge where stall_o=1.
  - Next-op acceptance happens only in IDLE with stall_o computed for the new op.
  - Implementation: an internal accepted flag blocks re-capture of the same op. The flag is set when BUS is entered and cleared when IDLE is re-entered with stall_o dropping for exactly one cycle. Execute advances on any cycle with stall_o=0.
- Timeout:
  - The counter increments each BUS cycle without ack.
  - On reaching TIMEOUT-1 with no ack: drop stb, pulse err_o for 1 cycle, no writeback, go to IDLE.
  - An ack arriving on that same cycle wins over the timeout.
- in_load and in_store both 1: treated as a load.
- in_rd=0 ALU op: forwarded as-is; register 0 is masked on read downstream.
- A late ack in IDLE is ignored.
- Reset in BUS or WB: stb drops at once and the pending writeback is discarded.

Test Plan:
- Three back-to-back ALU ops (rd=1,2,3; alu=0x11,0x22,0x33) -> wb_we3=1 on 3 consecutive cycles with matching ra3/wd3; stall_o=0 throughout.
- Low load, addr 0x100, rd=5, ack 2 cycles after stb, dat_i=0xBEEF -> stb high 3 cycles; then one WB cycle: wb_wd3=0x0000BEEF, highlow=0, memtoreg=1, data_ack=1, ra3=5.
- High store, addr 0x200, sdata=0xCAFE0000 -> data_we_o=1, data_dat_o=0xCAFE, addr=0x200 stable until ack; wb_we3 never asserts.
- TIMEOUT=16, load with ack never given -> stb drops after 16 cycles, err_o pulses once, no wb_we3, stall_o released.
- Reset asserted on the 2nd BUS cycle -> next cycle stb=0, stall_o=0, wb_we3=0; a later ack is ignored.
- Ack on the exact timeout cycle -> normal writeback, err_o stays 0.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Data-bus interface between the memory/writeback stage and the memory.
//
// The master side (the pipeline stage) drives the address, write data,
// write qualifier and the request strobe. The slave side (the memory)
// returns read data and an acknowledge that completes the transfer.
//
//   data_addr_o  32  byte address of the half-word transfer
//   data_dat_o   16  write data (valid when data_we_o=1)
//   data_we_o     1  1 = write, 0 = read
//   data_stb_o    1  transfer request, held until acknowledged
//   data_dat_i   16  read data, sampled on the acknowledge cycle
//   data_ack_i    1  transfer complete
interface mem_wb_stage_if;
    logic [31:0] data_addr_o;
    logic [15:0] data_dat_o;
    logic        data_we_o;
    logic        data_stb_o;
    logic [15:0] data_dat_i;
    logic        data_ack_i;

    modport master (
        output data_addr_o,
        output data_dat_o,
        output data_we_o,
        output data_stb_o,
        input  data_dat_i,
        input  data_ack_i
    );

    modport slave (
        input  data_addr_o,
        input  data_dat_o,
        input  data_we_o,
        input  data_stb_o,
        output data_dat_i,
        output data_ack_i
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage of the cpu2 pipeline.
//
// ALU results pass straight through to the register-file write port with
// one cycle of latency. Half-word loads and stores run on the 16-bit data
// bus (stb/ack handshake) while execute is held stalled; a load finishes
// with a single writeback cycle of the zero-extended bus data. A transfer
// that is not acknowledged within TIMEOUT strobe cycles is aborted and
// flagged on err_o.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_*              instruction from execute (valid, load, store, we,
//                     highlow, rd, alu result / address, store data)
//   stall_o           execute must hold its outputs (combinational)
//   bus               data-bus master port (addr, dat_o, we, stb / dat_i, ack)
//   wb_*              register-file write port (ra3, wd3, we3, highlow,
//                     memtoreg, data_ack)
//   err_o             one-cycle pulse when a transfer times out
module mem_wb_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic           in_load,
    input  logic           in_store,
    input  logic           in_we,
    input  logic           in_highlow,
    input  logic [4:0]     in_rd,
    input  logic [31:0]    in_alu,
    input  logic [31:0]    in_sdata,
    output logic           stall_o,
    mem_wb_stage_if.master bus,
    output logic [4:0]     wb_ra3,
    output logic [31:0]    wb_wd3,
    output logic           wb_we3,
    output logic           wb_highlow,
    output logic           wb_memtoreg,
    output logic           wb_data_ack,
    output logic           err_o
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_WB
    } state_t;

    // Counter value on the last strobe cycle before the transfer is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_reg;
    logic             accepted_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Latched memory operation.
    logic [4:0]       rd_reg;
    logic             highlow_reg;
    logic             is_load_reg;

    // Registered bus outputs.
    logic [31:0]      addr_reg;
    logic [15:0]      dat_o_reg;
    logic             we_reg;
    logic             stb_reg;

    // Registered writeback outputs.
    logic [4:0]       ra3_reg;
    logic [31:0]      wd3_reg;
    logic             we3_reg;
    logic             wb_hl_reg;
    logic             memtoreg_reg;
    logic             data_ack_reg;
    logic             err_reg;

    logic             mem_op;
    logic             take_op;
    logic [15:0]      store_half;

    assign mem_op     = in_load | in_store;
    // accepted_reg is only ever seen high in IDLE on the single cycle after a
    // memory op completes: execute is still presenting that same op, so it
    // must be neither re-captured nor stalled on, letting execute advance.
    assign take_op    = (state_reg == ST_IDLE) && in_valid && !accepted_reg;
    assign store_half = in_highlow ? in_sdata[31:16] : in_sdata[15:0];
    assign stall_o    = (state_reg != ST_IDLE) || (take_op && mem_op);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            accepted_reg <= 1'b0;
            cnt_reg      <= '0;
            rd_reg       <= '0;
            highlow_reg  <= 1'b0;
            is_load_reg  <= 1'b0;
            addr_reg     <= '0;
            dat_o_reg    <= '0;
            we_reg       <= 1'b0;
            stb_reg      <= 1'b0;
            ra3_reg      <= '0;
            wd3_reg      <= '0;
            we3_reg      <= 1'b0;
            wb_hl_reg    <= 1'b0;
            memtoreg_reg <= 1'b0;
            data_ack_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            // Write strobes and the error flag are single-cycle pulses.
            we3_reg      <= 1'b0;
            memtoreg_reg <= 1'b0;
            data_ack_reg <= 1'b0;
            err_reg      <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    accepted_reg <= 1'b0;
                    if (take_op) begin
                        if (mem_op) begin
                            addr_reg     <= in_alu;
                            dat_o_reg    <= store_half;
                            // A load+store encoding is executed as a load.
                            we_reg       <= in_store & ~in_load;
                            stb_reg      <= 1'b1;
                            rd_reg       <= in_rd;
                            highlow_reg  <= in_highlow;
                            is_load_reg  <= in_load;
                            cnt_reg      <= '0;
                            accepted_reg <= 1'b1;
                            state_reg    <= ST_BUS;
                        end else begin
                            we3_reg   <= in_we;
                            ra3_reg   <= in_rd;
                            wd3_reg   <= in_alu;
                            wb_hl_reg <= 1'b0;
                        end
                    end
                end

                ST_BUS: begin
                    // Ack is tested first so an ack on the final cycle wins.
                    if (bus.data_ack_i) begin
                        stb_reg <= 1'b0;
                        we_reg  <= 1'b0;
                        if (is_load_reg) begin
                            // Write port is loaded now so it is valid
                            // throughout the WB cycle.
                            we3_reg      <= 1'b1;
                            memtoreg_reg <= 1'b1;
                            data_ack_reg <= 1'b1;
                            wb_hl_reg    <= highlow_reg;
                            ra3_reg      <= rd_reg;
                            wd3_reg      <= {16'h0000, bus.data_dat_i};
                            state_reg    <= ST_WB;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        stb_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        err_reg   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                ST_WB: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.data_addr_o = addr_reg;
    assign bus.data_dat_o  = dat_o_reg;
    assign bus.data_we_o   = we_reg;
    assign bus.data_stb_o  = stb_reg;

    assign wb_ra3      = ra3_reg;
    assign wb_wd3      = wd3_reg;
    assign wb_we3      = we3_reg;
    assign wb_highlow  = wb_hl_reg;
    assign wb_memtoreg = memtoreg_reg;
    assign wb_data_ack = data_ack_reg;
    assign err_o       = err_reg;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a table of ALU vectors, hand-written
// memory-op sequences for the multi-cycle corners, and a randomized run
// checked against a transaction-level model of the stage.
module tb_mem_wb_stage;
    localparam int TIMEOUT = 16;
    localparam int N_OPS   = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_load, in_store, in_we, in_highlow;
    logic [4:0]  in_rd;
    logic [31:0] in_alu, in_sdata;
    logic        stall_o;
    logic [4:0]  wb_ra3;
    logic [31:0] wb_wd3;
    logic        wb_we3, wb_highlow, wb_memtoreg, wb_data_ack, err_o;

    mem_wb_stage_if bus_if ();

    mem_wb_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_load    (in_load),
        .in_store   (in_store),
        .in_we      (in_we),
        .in_highlow (in_highlow),
        .in_rd      (in_rd),
        .in_alu     (in_alu),
        .in_sdata   (in_sdata),
        .stall_o    (stall_o),
        .bus        (bus_if),
        .wb_ra3     (wb_ra3),
        .wb_wd3     (wb_wd3),
        .wb_we3     (wb_we3),
        .wb_highlow (wb_highlow),
        .wb_memtoreg(wb_memtoreg),
        .wb_data_ack(wb_data_ack),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic v, input logic ld, input logic st, input logic we,
                            input logic hl, input logic [4:0] rd, input logic [31:0] alu,
                            input logic [31:0] sd);
        in_valid   = v;
        in_load    = ld;
        in_store   = st;
        in_we      = we;
        in_highlow = hl;
        in_rd      = rd;
        in_alu     = alu;
        in_sdata   = sd;
    endtask

    function automatic logic [39:0] wb_vec();
        return {wb_ra3, wb_wd3, wb_highlow, wb_memtoreg, wb_data_ack};
    endfunction

    // ---------------- table of ALU vectors ----------------
    typedef struct {
        logic        valid, we, hl;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic        e_stall, e_we3;
        logic [4:0]  e_ra3;
        logic [31:0] e_wd3;
    } vec_t;

    function automatic vec_t mkv(input logic v, input logic we, input logic hl,
                                 input logic [4:0] rd, input logic [31:0] alu,
                                 input logic e_stall, input logic e_we3,
                                 input logic [4:0] e_ra3, input logic [31:0] e_wd3);
        vec_t r;
        r.valid = v; r.we = we; r.hl = hl; r.rd = rd; r.alu = alu;
        r.e_stall = e_stall; r.e_we3 = e_we3; r.e_ra3 = e_ra3; r.e_wd3 = e_wd3;
        return r;
    endfunction

    // ---------------- one memory op with a scripted slave ----------------
    task automatic run_mem(input logic ld, input logic st, input logic hl, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input int ack_at, input logic [15:0] rdata,
                           input logic exp_we, input logic [15:0] exp_dat,
                           output int stbc, output int wbc, output logic [39:0] wbv,
                           output int errc, output int bus_bad, output logic released);
        stbc = 0; wbc = 0; wbv = '0; errc = 0; bus_bad = 0; released = 1'b0;
        @(posedge clk); #1;
        drive_op(1'b1, ld, st, 1'b1, hl, rd, addr, sdata);
        bus_if.data_ack_i = 1'b0;
        @(negedge clk);
        check("mem_stall_on_accept", 64'(stall_o), 64'd1);
        for (int c = 0; c < 40 && !released; c++) begin
            @(posedge clk); #1;
            if (bus_if.data_stb_o) begin
                stbc++;
                bus_if.data_ack_i = (stbc == ack_at);
                bus_if.data_dat_i = rdata;
            end else begin
                bus_if.data_ack_i = 1'b0;
            end
            @(negedge clk);
            if (bus_if.data_stb_o) begin
                if ({bus_if.data_addr_o, bus_if.data_we_o, bus_if.data_dat_o} !== {addr, exp_we, exp_dat}
                    || !stall_o)
                    bus_bad++;
            end
            if (wb_we3) begin
                wbc++;
                wbv = wb_vec();
                $display("  wb write ra3=%0d wd3=%h hl=%0d mtr=%0d", wb_ra3, wb_wd3, wb_highlow, wb_memtoreg);
            end
            if (err_o) errc++;
            if (!stall_o) released = 1'b1;
        end
        @(posedge clk); #1;
        drive_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        bus_if.data_ack_i = 1'b0;
        $display("  mem op addr=%h ld=%0d st=%0d: stb_cycles=%0d writes=%0d errs=%0d", addr, ld, st, stbc, wbc, errc);
    endtask

    // ---------------- randomized run vs transaction model ----------------
    typedef struct {
        logic        valid, load, store, we, hl;
        logic [4:0]  rd;
        logic [31:0] alu, sdata;
    } op_t;

    op_t         ops [N_OPS];
    logic [48:0] bus_exp [N_OPS];
    int          ack_plan [N_OPS];
    logic [15:0] rdata_plan [N_OPS];
    logic [39:0] exp_wr [$];

    task automatic run_random();
        int m_total, err_exp, op_i, txn, stbc, nerr, cyc, drain, kind, r;
        logic prev_stb;
        logic [15:0] half;
        logic [39:0] w;
        m_total = 0; err_exp = 0;
        exp_wr.delete();
        for (int i = 0; i < N_OPS; i++) begin
            kind          = int'($urandom_range(0, 5));
            ops[i].valid  = ($urandom_range(0, 5) != 0);
            ops[i].load   = (kind == 3) || (kind == 5);
            ops[i].store  = (kind == 4) || (kind == 5);
            ops[i].we     = ($urandom_range(0, 3) != 0);
            ops[i].hl     = 1'($urandom_range(0, 1));
            ops[i].rd     = 5'($urandom_range(0, 31));
            ops[i].alu    = $urandom;
            ops[i].sdata  = $urandom;
        end
        // Expected bus transfers and register writes, in program order.
        for (int i = 0; i < N_OPS; i++) begin
            if (!ops[i].valid) continue;
            if (ops[i].load || ops[i].store) begin
                half = ops[i].hl ? ops[i].sdata[31:16] : ops[i].sdata[15:0];
                bus_exp[m_total] = {ops[i].alu, !ops[i].load, half};
                r = int'($urandom_range(0, 9));
                ack_plan[m_total]   = (r == 0) ? 0 : (r == 1) ? TIMEOUT : int'($urandom_range(1, 5));
                rdata_plan[m_total] = 16'($urandom);
                if (ack_plan[m_total] == 0)
                    err_exp++;
                else if (ops[i].load)
                    exp_wr.push_back({ops[i].rd, 16'h0000, rdata_plan[m_total], ops[i].hl, 1'b1, 1'b1});
                m_total++;
            end else if (ops[i].we) begin
                exp_wr.push_back({ops[i].rd, ops[i].alu, 3'b000});
            end
        end

        op_i = 0; txn = 0; stbc = 0; nerr = 0; cyc = 0; drain = 0; prev_stb = 1'b0;
        while ((op_i < N_OPS || drain < 20) && cyc < 6000) begin
            cyc++;
            @(posedge clk); #1;
            if (op_i < N_OPS)
                drive_op(ops[op_i].valid, ops[op_i].load, ops[op_i].store, ops[op_i].we,
                         ops[op_i].hl, ops[op_i].rd, ops[op_i].alu, ops[op_i].sdata);
            else
                drive_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
            if (bus_if.data_stb_o) begin
                if (!prev_stb) stbc = 0;
                stbc++;
                bus_if.data_ack_i = (txn < m_total) && (stbc == ack_plan[txn]);
                bus_if.data_dat_i = (txn < m_total) ? rdata_plan[txn] : 16'h0000;
            end else begin
                if (prev_stb) txn++;
                // Stray acks outside a transfer must be ignored.
                bus_if.data_ack_i = ($urandom_range(0, 7) == 0);
                bus_if.data_dat_i = 16'($urandom);
            end
            prev_stb = bus_if.data_stb_o;
            @(negedge clk);
            if (bus_if.data_stb_o) begin
                if (txn < m_total)
                    check("rand_bus", 64'({bus_if.data_addr_o, bus_if.data_we_o, bus_if.data_dat_o}),
                          64'(bus_exp[txn]));
                else
                    check("rand_extra_txn", 64'(txn), 64'(m_total - 1));
            end
            if (wb_we3) begin
                if (exp_wr.size() == 0) begin
                    check("rand_unexpected_wb", 64'(wb_vec()), 64'd0);
                end else begin
                    w = exp_wr.pop_front();
                    check("rand_wb", 64'(wb_vec()), 64'(w));
                    $display("  rand wb ra3=%0d wd3=%h mtr=%0d", wb_ra3, wb_wd3, wb_memtoreg);
                end
            end
            if (err_o) nerr++;
            if (op_i < N_OPS) begin
                if (!stall_o) op_i++;
            end else begin
                drain++;
            end
        end
        check("rand_cycle_budget", 64'(cyc < 6000), 64'd1);
        check("rand_writes_left", 64'(exp_wr.size()), 64'd0);
        check("rand_err_count", 64'(nerr), 64'(err_exp));
        check("rand_txn_count", 64'(txn), 64'(m_total));
        $display("  random run: ops=%0d transfers=%0d timeouts=%0d cycles=%0d", N_OPS, m_total, err_exp, cyc);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t        vecs [7];
        int          stbc, wbc, errc, bus_bad;
        logic [39:0] wbv;
        logic        released;

        reset = 1'b1;
        drive_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        bus_if.data_ack_i = 1'b0;
        bus_if.data_dat_i = 16'h0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_bus_outs", 64'({stall_o, bus_if.data_stb_o, bus_if.data_we_o,
                                     bus_if.data_addr_o, bus_if.data_dat_o}), 64'd0);
        check("reset_wb_outs", 64'({wb_ra3, wb_wd3, wb_we3, wb_highlow, wb_memtoreg,
                                    wb_data_ack, err_o}), 64'd0);

        // Back-to-back ALU ops: outputs of row i appear in row i+1.
        vecs[0] = mkv(1'b1, 1'b1, 1'b0, 5'd1, 32'h11,       1'b0, 1'b0, 5'd0, 32'h0);
        vecs[1] = mkv(1'b1, 1'b1, 1'b0, 5'd2, 32'h22,       1'b0, 1'b1, 5'd1, 32'h11);
        vecs[2] = mkv(1'b1, 1'b1, 1'b1, 5'd3, 32'h33,       1'b0, 1'b1, 5'd2, 32'h22);
        vecs[3] = mkv(1'b1, 1'b1, 1'b0, 5'd0, 32'hDEAD0000, 1'b0, 1'b1, 5'd3, 32'h33);
        vecs[4] = mkv(1'b1, 1'b0, 1'b0, 5'd7, 32'h77,       1'b0, 1'b1, 5'd0, 32'hDEAD0000);
        vecs[5] = mkv(1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0);
        vecs[6] = mkv(1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            drive_op(vecs[i].valid, 1'b0, 1'b0, vecs[i].we, vecs[i].hl, vecs[i].rd, vecs[i].alu, 32'd0);
            @(negedge clk);
            $display("  vec %0d: rd=%0d alu=%h -> we3=%0d ra3=%0d wd3=%h", i, vecs[i].rd, vecs[i].alu,
                     wb_we3, wb_ra3, wb_wd3);
            check("alu_stall", 64'(stall_o), 64'(vecs[i].e_stall));
            check("alu_we3", 64'(wb_we3), 64'(vecs[i].e_we3));
            if (vecs[i].e_we3)
                check("alu_wb", 64'(wb_vec()), 64'({vecs[i].e_ra3, vecs[i].e_wd3, 3'b000}));
        end

        // Low load, ack on the third strobe cycle.
        run_mem(1'b1, 1'b0, 1'b0, 5'd5, 32'h100, 32'h0, 3, 16'hBEEF, 1'b0, 16'h0000,
                stbc, wbc, wbv, errc, bus_bad, released);
        check("load_stb_cycles", 64'(stbc), 64'd3);
        check("load_wb_count", 64'(wbc), 64'd1);
        check("load_wb", 64'(wbv), 64'({5'd5, 32'h0000BEEF, 1'b0, 1'b1, 1'b1}));
        check("load_bus_stable", 64'(bus_bad), 64'd0);
        check("load_released", 64'(released), 64'd1);

        // High store.
        run_mem(1'b0, 1'b1, 1'b1, 5'd4, 32'h200, 32'hCAFE0000, 4, 16'h0000, 1'b1, 16'hCAFE,
                stbc, wbc, wbv, errc, bus_bad, released);
        check("store_stb_cycles", 64'(stbc), 64'd4);
        check("store_no_wb", 64'(wbc), 64'd0);
        check("store_bus_stable", 64'(bus_bad), 64'd0);
        check("store_no_err", 64'(errc), 64'd0);

        // Load with no ack at all: timeout.
        run_mem(1'b1, 1'b0, 1'b0, 5'd6, 32'h400, 32'h0, 0, 16'h5555, 1'b0, 16'h0000,
                stbc, wbc, wbv, errc, bus_bad, released);
        check("timeout_stb_cycles", 64'(stbc), 64'(TIMEOUT));
        check("timeout_err_pulses", 64'(errc), 64'd1);
        check("timeout_no_wb", 64'(wbc), 64'd0);
        check("timeout_released", 64'(released), 64'd1);
        @(negedge clk);
        check("timeout_err_cleared", 64'(err_o), 64'd0);

        // Ack on the exact timeout cycle wins.
        run_mem(1'b1, 1'b0, 1'b0, 5'd7, 32'h404, 32'h0, TIMEOUT, 16'h1357, 1'b0, 16'h0000,
                stbc, wbc, wbv, errc, bus_bad, released);
        check("edge_ack_stb_cycles", 64'(stbc), 64'(TIMEOUT));
        check("edge_ack_no_err", 64'(errc), 64'd0);
        check("edge_ack_wb", 64'(wbv), 64'({5'd7, 32'h00001357, 1'b0, 1'b1, 1'b1}));

        // Load and store both set: a high-half load.
        run_mem(1'b1, 1'b1, 1'b1, 5'd8, 32'h500, 32'hA5A50F0F, 1, 16'h8001, 1'b0, 16'hA5A5,
                stbc, wbc, wbv, errc, bus_bad, released);
        check("both_stb_cycles", 64'(stbc), 64'd1);
        check("both_bus_read", 64'(bus_bad), 64'd0);
        check("both_wb", 64'(wbv), 64'({5'd8, 32'h00008001, 1'b1, 1'b1, 1'b1}));

        // Reset on the second BUS cycle, then a late ack.
        @(posedge clk); #1;
        drive_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h300, 32'h0);
        @(posedge clk); #1;                         // BUS cycle 1
        @(posedge clk); #1;                         // BUS cycle 2
        reset = 1'b1;
        drive_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("rst_bus_stb_before", 64'(bus_if.data_stb_o), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_bus_after", 64'({bus_if.data_stb_o, stall_o, wb_we3}), 64'd0);
        @(posedge clk); #1;
        bus_if.data_ack_i = 1'b1;
        bus_if.data_dat_i = 16'h1234;
        @(negedge clk);
        check("late_ack_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        bus_if.data_ack_i = 1'b0;
        @(negedge clk);
        check("late_ack_ignored", 64'({wb_we3, err_o, bus_if.data_stb_o}), 64'd0);
        $display("  reset-in-bus sequence done");

        // Randomized run from a clean reset.
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        run_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "simulation time limit");
    end
endmodule
